// File: rtl/morse_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : morse_encoder
//  Description : Accepts one ASCII character at a time and emits its
//                International Morse code as one-cycle dot/dash pulses,
//                followed by an end-of-character or word-separator pulse and
//                a programmable idle gap. Unsupported characters raise err.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_encoder #(
   parameter int ELEM_GAP = 1,
   parameter int CHAR_GAP = 3,
   parameter int WORD_GAP = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       dot_out,
   output logic       dash_out,
   output logic       char_space_out,
   output logic       word_space_out,
   output logic       err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SYM    = 3'd1;
   localparam logic [2:0] S_EGAP   = 3'd2;
   localparam logic [2:0] S_CSPACE = 3'd3;
   localparam logic [2:0] S_CWAIT  = 3'd4;
   localparam logic [2:0] S_WSPACE = 3'd5;
   localparam logic [2:0] S_WWAIT  = 3'd6;
   localparam logic [2:0] S_ERR    = 3'd7;

   // The gap counter is loaded with gap-1 on entry to a wait state and the
   // state is left on the cycle the counter reads zero, giving exactly
   // "gap" idle cycles.
   localparam logic [3:0] c_elem_load = (ELEM_GAP > 0) ? 4'(ELEM_GAP - 1) : 4'd0;
   localparam logic [3:0] c_char_load = (CHAR_GAP > 0) ? 4'(CHAR_GAP - 1) : 4'd0;
   localparam logic [3:0] c_word_load = (WORD_GAP > 0) ? 4'(WORD_GAP - 1) : 4'd0;

   logic [2:0] r_state;
   logic [2:0] w_next;
   logic [2:0] r_sym_cnt;
   logic [3:0] r_gap_cnt;
   logic [2:0] r_len;
   logic [4:0] r_pat;
   logic [7:0] w_folded;
   logic [8:0] w_code;
   logic       w_is_space;
   logic       w_accept;
   logic       w_last;

   // {supported, length, pattern}; pattern is left-justified, MSB is the
   // first symbol sent, 1 = dash, 0 = dot.
   function automatic logic [8:0] morse_code(input logic [7:0] ch);
      logic [8:0] code;
      code = 9'd0;
      case (ch)
         "A": code = {1'b1, 3'd2, 5'b01000};
         "B": code = {1'b1, 3'd4, 5'b10000};
         "C": code = {1'b1, 3'd4, 5'b10100};
         "D": code = {1'b1, 3'd3, 5'b10000};
         "E": code = {1'b1, 3'd1, 5'b00000};
         "F": code = {1'b1, 3'd4, 5'b00100};
         "G": code = {1'b1, 3'd3, 5'b11000};
         "H": code = {1'b1, 3'd4, 5'b00000};
         "I": code = {1'b1, 3'd2, 5'b00000};
         "J": code = {1'b1, 3'd4, 5'b01110};
         "K": code = {1'b1, 3'd3, 5'b10100};
         "L": code = {1'b1, 3'd4, 5'b01000};
         "M": code = {1'b1, 3'd2, 5'b11000};
         "N": code = {1'b1, 3'd2, 5'b10000};
         "O": code = {1'b1, 3'd3, 5'b11100};
         "P": code = {1'b1, 3'd4, 5'b01100};
         "Q": code = {1'b1, 3'd4, 5'b11010};
         "R": code = {1'b1, 3'd3, 5'b01000};
         "S": code = {1'b1, 3'd3, 5'b00000};
         "T": code = {1'b1, 3'd1, 5'b10000};
         "U": code = {1'b1, 3'd3, 5'b00100};
         "V": code = {1'b1, 3'd4, 5'b00010};
         "W": code = {1'b1, 3'd3, 5'b01100};
         "X": code = {1'b1, 3'd4, 5'b10010};
         "Y": code = {1'b1, 3'd4, 5'b10110};
         "Z": code = {1'b1, 3'd4, 5'b11000};
         "0": code = {1'b1, 3'd5, 5'b11111};
         "1": code = {1'b1, 3'd5, 5'b01111};
         "2": code = {1'b1, 3'd5, 5'b00111};
         "3": code = {1'b1, 3'd5, 5'b00011};
         "4": code = {1'b1, 3'd5, 5'b00001};
         "5": code = {1'b1, 3'd5, 5'b00000};
         "6": code = {1'b1, 3'd5, 5'b10000};
         "7": code = {1'b1, 3'd5, 5'b11000};
         "8": code = {1'b1, 3'd5, 5'b11100};
         "9": code = {1'b1, 3'd5, 5'b11110};
         default: code = 9'd0;
      endcase
      return code;
   endfunction

   // Lowercase letters share the uppercase table entries.
   assign w_folded   = (char_in >= 8'h61 && char_in <= 8'h7A) ? (char_in - 8'h20) : char_in;
   assign w_code     = morse_code(w_folded);
   assign w_is_space = (char_in == 8'h20);
   assign w_accept   = char_valid && char_ready;
   assign w_last     = ((r_sym_cnt + 3'd1) == r_len);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_is_space)     w_next = S_WSPACE;
               else if (w_code[8]) w_next = S_SYM;
               else                w_next = S_ERR;
            end
         end
         S_SYM: begin
            if (w_last)             w_next = S_CSPACE;
            else if (ELEM_GAP == 0) w_next = S_SYM;
            else                    w_next = S_EGAP;
         end
         S_EGAP:   if (r_gap_cnt == 4'd0) w_next = S_SYM;
         S_CSPACE: w_next = (CHAR_GAP == 0) ? S_IDLE : S_CWAIT;
         S_CWAIT:  if (r_gap_cnt == 4'd0) w_next = S_IDLE;
         S_WSPACE: w_next = (WORD_GAP == 0) ? S_IDLE : S_WWAIT;
         S_WWAIT:  if (r_gap_cnt == 4'd0) w_next = S_IDLE;
         S_ERR:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Captured code, symbol counter and gap counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len     <= 3'd0;
         r_pat     <= 5'd0;
         r_sym_cnt <= 3'd0;
         r_gap_cnt <= 4'd0;
      end else begin
         if (w_accept) begin
            r_len     <= w_code[7:5];
            r_pat     <= w_code[4:0];
            r_sym_cnt <= 3'd0;
         end else if (r_state == S_SYM) begin
            r_sym_cnt <= r_sym_cnt + 3'd1;
            r_pat     <= {r_pat[3:0], 1'b0};
         end

         if (r_state != S_EGAP && w_next == S_EGAP)
            r_gap_cnt <= c_elem_load;
         else if (r_state != S_CWAIT && w_next == S_CWAIT)
            r_gap_cnt <= c_char_load;
         else if (r_state != S_WWAIT && w_next == S_WWAIT)
            r_gap_cnt <= c_word_load;
         else if (r_gap_cnt != 4'd0)
            r_gap_cnt <= r_gap_cnt - 4'd1;
      end
   end

   // Moore outputs decoded from the state; ready is held low during reset.
   always_comb begin
      char_ready     = 1'b0;
      dot_out        = 1'b0;
      dash_out       = 1'b0;
      char_space_out = 1'b0;
      word_space_out = 1'b0;
      err            = 1'b0;
      case (r_state)
         S_IDLE:   char_ready = !rst;
         S_SYM: begin
            dot_out  = !r_pat[4];
            dash_out = r_pat[4];
         end
         S_CSPACE: char_space_out = 1'b1;
         S_WSPACE: word_space_out = 1'b1;
         S_ERR:    err = 1'b1;
         default:  ;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/morse_encoder.md
MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 Parameter ELEM_GAP, default 1, idle cycles between symbols of one character (1..15).
REQ-002 Parameter CHAR_GAP, default 3, idle cycles after a char_space pulse before the next character is accepted.
REQ-003 Parameter WORD_GAP, default 7, idle cycles after a word_space pulse before the next character is accepted.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 char_in  input  8  ASCII character to encode.
REQ-007 char_valid  input  1  char_in is valid.
REQ-008 char_ready  output  1  encoder can accept a character this cycle.
REQ-009 dot_out  output  1  one-cycle dot symbol pulse.
REQ-010 dash_out  output  1  one-cycle dash symbol pulse.
REQ-011 char_space_out  output  1  one-cycle end-of-character pulse.
REQ-012 word_space_out  output  1  one-cycle word-separator pulse.
REQ-013 err  output  1  one-cycle pulse: unsupported character dropped.

Function
REQ-014 A character is accepted on a cycle with char_valid=1 and char_ready=1; char_valid while char_ready=0 is ignored and is not queued.
REQ-015 char_in is captured on acceptance; later changes to char_in do not affect the character in progress.
REQ-016 Supported set: 'A'-'Z' (0x41-0x5A), 'a'-'z' (0x61-0x7A, encoded as uppercase), '0'-'9' (0x30-0x39), space (0x20); standard International Morse table, 1-5 symbols per character, emitted left to right.
REQ-017 FSM states: IDLE, SYM, EGAP, CSPACE, CWAIT, WSPACE, WWAIT, ERR; char_ready=1 only in IDLE.
REQ-018 Letter/digit accepted at cycle T: first symbol pulse at T+1 (dot_out or dash_out), then ELEM_GAP all-zero cycles between consecutive symbols.
REQ-019 The cycle after the last symbol, char_space_out=1 (no element gap before it), then CHAR_GAP all-zero cycles with char_ready=0, then IDLE.
REQ-020 Space accepted at T: word_space_out=1 at T+1, then WORD_GAP all-zero cycles with char_ready=0, then IDLE; no char_space_out is emitted for a space.
REQ-021 Unsupported character accepted at T: err=1 at T+1 (ERR state); no symbol or space pulses; IDLE with char_ready=1 at T+2.
REQ-022 At most one of dot_out, dash_out, char_space_out, word_space_out, err is high in any cycle.
REQ-023 Each pulse output is high for exactly one cycle per event; none is high in IDLE.
REQ-024 Symbol counter is 3 bits, counts symbols emitted, and compares against the table length (1..5); gap counter is 4 bits, loads the gap parameter and counts down to 0.
REQ-025 Back-to-back characters: with char_valid held high, the next character is accepted on the first IDLE cycle, giving exactly CHAR_GAP+1 (or WORD_GAP+1) zero cycles between a space pulse and the next emitted pulse.
REQ-026 Consecutive spaces each produce a separate word_space_out pulse with its own WORD_GAP wait.

Reset
REQ-027 While rst=1, at every rising edge: state=IDLE, counters=0, captured character cleared, all pulse outputs=0, char_ready=0.
REQ-028 The first cycle after rst deasserts: char_ready=1, all pulse outputs=0.
REQ-029 rst asserted mid-character or mid-gap aborts the character; no partial char_space_out or word_space_out is emitted afterwards.

Verification
REQ-030 'E' (0x45) accepted at T -> dot_out at T+1, char_space_out at T+2, zeros T+3..T+5, char_ready=1 at T+6.
REQ-031 'a' (0x61) accepted at T -> dot T+1, idle T+2, dash T+3, char_space T+4, char_ready=1 at T+8; identical to 'A'.
REQ-032 '0' (0x30) -> five dash_out pulses at T+1,3,5,7,9, char_space_out at T+10; ' ' (0x20) -> word_space_out at T+1, char_ready=1 at T+9.
REQ-033 '?' (0x3F) -> err=1 at T+1, no other pulses, char_ready=1 at T+2; char_valid held high during busy cycles -> no extra acceptance.
REQ-034 rst=1 during the second symbol of 'A' -> all outputs 0 on the next edge, no char_space_out, char_ready=1 the cycle after rst deasserts.
REQ-035 Random stream with char_valid always high: the pulse output feeds the team's morse detector, and its decoded sout sequence must equal the supplied characters, with lowercase letters folded to uppercase.
